rand_req_arbiter: RTL and testbench

//   Shares one free-running 12-bit LFSR random source among NREQ requesters (game logic:

---
 rtl/rand_req_arbiter_if.sv | 30 +++
 rtl/rand_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_rand_req_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_req_arbiter_if.sv
// Request/response bundle between the random-source arbiter and its requesters.
// The master side is the game logic; the slave side is the arbiter.
interface rand_req_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 12
);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] range_i;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      rand_out;
   logic                  busy;

   modport master (
      output req,
      output range_i,
      input  ack,
      input  rand_out,
      input  busy
   );

   modport slave (
      input  req,
      input  range_i,
      output ack,
      output rand_out,
      output busy
   );

endinterface

// File: rtl/rand_req_arbiter.sv
// Round-robin arbiter sharing one free-running LFSR among NREQ requesters; each grant
// reduces a sample into [0, range) by repeated subtraction. Optional RAND_NO_REPEAT_EN.
module rand_req_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rand_in,
   rand_req_arbiter_if.slave bus
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, SAMPLE, REDUCE, DONE} state_t;

   state_t           state, state_n;
   logic [IDXW-1:0]  g, g_n;
   logic [IDXW-1:0]  last_grant, last_grant_n;
   logic [WIDTH-1:0] rng, rng_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic [WIDTH-1:0] rand_out_q, rand_out_n;
   logic [NREQ-1:0]  ack_q, ack_n;
   logic             grant_found;
   logic [IDXW-1:0]  grant_idx;
   logic [IDXW-1:0]  cand;
   logic             deliver;
   logic [WIDTH-1:0] ranges [NREQ];

`ifdef RAND_NO_REPEAT_EN
   logic [WIDTH-1:0] last_val [NREQ];
   logic [1:0]       retry, retry_n;
`endif

   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign ranges[k] = bus.range_i[k*WIDTH +: WIDTH];
   end

   // Search starts just after the previous winner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = IDXW'((int'(last_grant) + i) % NREQ);
         if (!grant_found && bus.req[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      state_n      = state;
      g_n          = g;
      last_grant_n = last_grant;
      rng_n        = rng;
      acc_n        = acc;
      rand_out_n   = rand_out_q;
      ack_n        = '0;
      deliver      = 1'b0;
`ifdef RAND_NO_REPEAT_EN
      retry_n      = retry;
`endif
      case (state)
         IDLE: begin
`ifdef RAND_NO_REPEAT_EN
            retry_n = 2'd0;
`endif
            if (grant_found) begin
               g_n          = grant_idx;
               last_grant_n = grant_idx;
               rng_n        = ranges[grant_idx];
               state_n      = SAMPLE;
            end
         end
         SAMPLE: begin
            acc_n   = rand_in;
            state_n = REDUCE;
         end
         REDUCE: begin
            // A zero range means "raw sample", so it never enters the subtract loop.
            if (rng != '0 && acc >= rng) begin
               acc_n = acc - rng;
            end else begin
               deliver = 1'b1;
`ifdef RAND_NO_REPEAT_EN
               if (acc == last_val[g] && retry != 2'd3) begin
                  deliver = 1'b0;
                  retry_n = retry + 2'd1;
                  state_n = SAMPLE;
               end
`endif
            end
            if (deliver) begin
               rand_out_n = acc;
               ack_n      = NREQ'(1) << g;
               state_n    = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Reset parks last_grant on the top index so requester 0 is searched first.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         g          <= '0;
         last_grant <= IDXW'(NREQ - 1);
         rng        <= '0;
         acc        <= '0;
         rand_out_q <= '0;
         ack_q      <= '0;
`ifdef RAND_NO_REPEAT_EN
         retry      <= 2'd0;
         for (int k = 0; k < NREQ; k++) begin
            last_val[k] <= '0;
         end
`endif
      end else begin
         state      <= state_n;
         g          <= g_n;
         last_grant <= last_grant_n;
         rng        <= rng_n;
         acc        <= acc_n;
         rand_out_q <= rand_out_n;
         ack_q      <= ack_n;
`ifdef RAND_NO_REPEAT_EN
         retry      <= retry_n;
         if (deliver) begin
            last_val[g] <= acc;
         end
`endif
      end
   end

   assign bus.ack      = ack_q;
   assign bus.rand_out = rand_out_q;
   assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Scoreboard bench for rand_req_arbiter: expected (ack, value) pairs are queued when a
// request is driven and popped when the arbiter acks.
module tb_rand_req_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 12;

   typedef struct packed {
      logic [NREQ-1:0]  ack;
      logic [WIDTH-1:0] val;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] rand_in;
   logic [WIDTH-1:0] rngs [NREQ];
   int               errors = 0;
   int               checks = 0;
   exp_t             sb [$];

   rand_req_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   assign bus.range_i = {rngs[3], rngs[2], rngs[1], rngs[0]};

   rand_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .rand_in (rand_in),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Advances one edge at a time and samples on the falling edge; cyc is the number of
   // rising edges seen, so an ack "after edge N" of a transaction appears at cyc = N+1.
   task automatic wait_ack(input int budget, output int cyc, output logic [NREQ-1:0] a,
                           output logic [WIDTH-1:0] v, output bit to);
      cyc = 0;
      to  = 1'b1;
      a   = '0;
      v   = '0;
      while (to && cyc < budget) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (bus.ack !== '0) begin
            a  = bus.ack;
            v  = bus.rand_out;
            to = 1'b0;
         end
      end
   endtask

   task automatic push_exp(input logic [NREQ-1:0] a, input logic [WIDTH-1:0] v);
      exp_t e;
      e.ack = a;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic test_reset;
      rst     = 1'b0;
      bus.req = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b want 0000", bus.ack); end
      checks++;
      if (bus.rand_out !== 12'd0) begin errors++; $display("[TB] FAIL reset_rand_out: got %0d want 0", bus.rand_out); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int cyc; logic [NREQ-1:0] a; logic [WIDTH-1:0] v; bit to; exp_t e;
      rngs[0] = 12'd10;
      rand_in = 12'd37;
      push_exp(4'b0001, 12'd7);
      bus.req = 4'b0001;
      wait_ack(50, cyc, a, v, to);
      bus.req = '0;
      checks++;
      if (to) begin
         errors++; $display("[TB] FAIL basic_timeout: no ack within 50 cycles");
         sb.delete();
      end else begin
         e = sb.pop_front();
         checks++;
         if (a !== e.ack) begin errors++; $display("[TB] FAIL basic_ack: got %b want %b", a, e.ack); end
         checks++;
         if (v !== e.val) begin errors++; $display("[TB] FAIL basic_value: got %0d want %0d", v, e.val); end
         checks++;
         if (cyc - 1 !== 5) begin errors++; $display("[TB] FAIL basic_latency: ack after edge %0d want 5", cyc - 1); end
         checks++;
         if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_done: got %b want 1", bus.busy); end
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL basic_ack_pulse: got %b want 0000", bus.ack); end
         checks++;
         if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_idle: got %b want 0", bus.busy); end
         checks++;
         if (bus.rand_out !== 12'd7) begin errors++; $display("[TB] FAIL basic_hold: got %0d want 7", bus.rand_out); end
      end
   endtask

   task automatic test_zero_range;
      int cyc; logic [NREQ-1:0] a; logic [WIDTH-1:0] v; bit to; exp_t e;
      rngs[2] = 12'd0;
      rand_in = 12'hABC;
      push_exp(4'b0100, 12'hABC);
      bus.req = 4'b0100;
      wait_ack(50, cyc, a, v, to);
      bus.req = '0;
      checks++;
      if (to) begin
         errors++; $display("[TB] FAIL zero_range_timeout: no ack within 50 cycles");
         sb.delete();
      end else begin
         e = sb.pop_front();
         checks++;
         if (a !== e.ack || v !== e.val) begin
            errors++; $display("[TB] FAIL zero_range_result: got ack %b val %h want ack %b val %h", a, v, e.ack, e.val);
         end
         checks++;
         if (cyc - 1 !== 2) begin errors++; $display("[TB] FAIL zero_range_latency: ack after edge %0d want 2", cyc - 1); end
      end
      @(posedge clk);
      @(negedge clk);
      // Range larger than the sample, then changed after the grant edge: must be ignored.
      rngs[3] = 12'd100;
      rand_in = 12'd37;
      push_exp(4'b1000, 12'd37);
      bus.req = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      rngs[3] = 12'd3;
      wait_ack(50, cyc, a, v, to);
      bus.req = '0;
      checks++;
      if (to) begin
         errors++; $display("[TB] FAIL big_range_timeout: no ack within 50 cycles");
         sb.delete();
      end else begin
         e = sb.pop_front();
         checks++;
         if (a !== e.ack || v !== e.val) begin
            errors++; $display("[TB] FAIL big_range_result: got ack %b val %0d want ack %b val %0d", a, v, e.ack, e.val);
         end
         checks++;
         if (cyc !== 2) begin errors++; $display("[TB] FAIL big_range_latency: ack after edge %0d want 2", cyc); end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int cyc; logic [NREQ-1:0] a; logic [WIDTH-1:0] v; bit to; exp_t e;
      rngs[0] = 12'd5;
      rngs[1] = 12'd5;
      rand_in = 12'd37;
      push_exp(4'b0001, 12'd2);
      push_exp(4'b0010, 12'd2);
      push_exp(4'b0001, 12'd2);
      push_exp(4'b0010, 12'd2);
      bus.req = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         wait_ack(400, cyc, a, v, to);
         checks++;
         if (to) begin
            errors++; $display("[TB] FAIL b2b_timeout: ack %0d missing", i);
            break;
         end
         e = sb.pop_front();
         checks++;
         if (a !== e.ack) begin errors++; $display("[TB] FAIL b2b_order: ack %0d got %b want %b", i, a, e.ack); end
         checks++;
         if (v !== e.val) begin errors++; $display("[TB] FAIL b2b_value: ack %0d got %0d want %0d", i, v, e.val); end
         checks++;
         if (cyc <= 1) begin errors++; $display("[TB] FAIL b2b_guard: ack %0d only %0d cycle after previous, want >1", i, cyc); end
      end
      bus.req = '0;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int cyc; int ack_seen; logic [NREQ-1:0] a; logic [WIDTH-1:0] v; bit to; exp_t e;
      rngs[0]  = 12'd1;
      rand_in  = 12'd4095;
      bus.req  = 4'b0001;
      ack_seen = 0;
      repeat (100) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.ack !== '0) ack_seen++;
      end
      checks++;
      if (ack_seen !== 0) begin errors++; $display("[TB] FAIL long_no_ack: got %0d acks want 0", ack_seen); end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL long_busy: got %b want 1", bus.busy); end
      rst     = 1'b0;
      bus.req = '0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.rand_out !== 12'd0) begin
         errors++; $display("[TB] FAIL mid_reset: got ack %b busy %b val %0d want 0000 0 0", bus.ack, bus.busy, bus.rand_out);
      end
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b1;
      ack_seen = 0;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.ack !== '0 || bus.busy !== 1'b0) ack_seen++;
      end
      checks++;
      if (ack_seen !== 0) begin errors++; $display("[TB] FAIL post_reset_idle: %0d active cycles want 0", ack_seen); end
      rngs[0] = 12'd5;
      rngs[1] = 12'd5;
      rand_in = 12'd37;
      push_exp(4'b0001, 12'd2);
      bus.req = 4'b0011;
      wait_ack(200, cyc, a, v, to);
      bus.req = '0;
      checks++;
      if (to) begin
         errors++; $display("[TB] FAIL post_reset_timeout: no ack within 200 cycles");
         sb.delete();
      end else begin
         e = sb.pop_front();
         checks++;
         if (a !== e.ack || v !== e.val) begin
            errors++; $display("[TB] FAIL post_reset_grant: got ack %b val %0d want ack %b val %0d", a, v, e.ack, e.val);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_no_repeat;
      int cyc; int want_edge; logic [NREQ-1:0] a; logic [WIDTH-1:0] v; bit to; exp_t e;
`ifdef RAND_NO_REPEAT_EN
      want_edge = 20;
`else
      want_edge = 5;
`endif
      rst     = 1'b0;
      bus.req = '0;
      @(posedge clk);
      @(negedge clk);
      rst     = 1'b1;
      rngs[0] = 12'd10;
      rand_in = 12'd37;
      for (int t = 0; t < 2; t++) begin
         push_exp(4'b0001, 12'd7);
         bus.req = 4'b0001;
         wait_ack(100, cyc, a, v, to);
         bus.req = '0;
         checks++;
         if (to) begin
            errors++; $display("[TB] FAIL repeat_timeout: request %0d got no ack", t);
            sb.delete();
         end else begin
            e = sb.pop_front();
            checks++;
            if (a !== e.ack || v !== e.val) begin
               errors++; $display("[TB] FAIL repeat_result: request %0d got ack %b val %0d want ack %b val %0d", t, a, v, e.ack, e.val);
            end
            checks++;
            if (cyc - 1 !== ((t == 0) ? 5 : want_edge)) begin
               errors++; $display("[TB] FAIL repeat_latency: request %0d ack after edge %0d want %0d", t, cyc - 1, (t == 0) ? 5 : want_edge);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      rst     = 1'b0;
      rand_in = '0;
      bus.req = '0;
      for (int k = 0; k < NREQ; k++) rngs[k] = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_zero_range();
      test_back_to_back();
      test_reset_mid();
      test_no_repeat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
